imem_loader: RTL

Writer side of the 16-bit instruction memory read by the fetch stage: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them sequentially from `BASE_ADDR`. It holds the pipelined core in reset via `cpu_hold` until a complete, checksum-verified image is in memory. It sits between the host/UART byte source and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared CPU package: instruction/PC widths and the loader state encoding
// used by the instruction memory writer.
package imem_loader_pkg;

   localparam int INSTR_W = 16;
   localparam int PC_W    = 8;
   localparam int BYTE_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } loader_state_t;

   // States in which the byte stream is being consumed.
   function automatic logic is_loading(input loader_state_t s);
      return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CHECK);
   endfunction

   // States from which a start pulse launches a new load.
   function automatic logic is_restartable(input loader_state_t s);
      return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader: turns a checksummed byte frame into sequential
// big-endian 16-bit word writes and holds the core in reset until verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                ADDR_W    = PC_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   input  logic [BYTE_W-1:0]   in_data,
   output logic                in_ready,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [INSTR_W-1:0]  wr_data,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                cpu_hold
);

   loader_state_t state_q, state_d;

   logic [BYTE_W-1:0]  count_q, count_d;
   logic [BYTE_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0]  csum_q, csum_d;
   logic [BYTE_W-1:0]  hi_q, hi_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [INSTR_W-1:0] wr_data_q, wr_data_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               cpu_hold_q, cpu_hold_d;

   logic xfer;
   logic last_word;
   logic csum_ok;

   assign xfer      = in_valid && in_ready;
   assign last_word = ((idx_q + 8'd1) == count_q);
   assign csum_ok   = (in_data == csum_q);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so
   // no path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (xfer) state_d = (in_data == '0) ? S_CHECK : S_HI;
         end
         S_HI: begin
            if (xfer) state_d = S_LO;
         end
         S_LO: begin
            if (xfer) state_d = last_word ? S_CHECK : S_HI;
         end
         S_CHECK: begin
            if (xfer) state_d = csum_ok ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (status flags are registered alongside the state)
   // ---------------------------------------------------------------------
   always_comb begin
      in_ready   = is_loading(state_q);
      busy       = is_loading(state_q);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERROR);
      cpu_hold_d = (state_d != S_DONE);
   end

   // ---------------------------------------------------------------------
   // Datapath: word assembly, checksum, write port
   // ---------------------------------------------------------------------
   always_comb begin
      count_d   = count_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      hi_d      = hi_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (xfer) begin
         unique case (state_q)
            S_COUNT: begin
               count_d = in_data;
               csum_d  = in_data;
               idx_d   = '0;
            end
            S_HI: begin
               hi_d   = in_data;
               csum_d = csum_q ^ in_data;
            end
            S_LO: begin
               csum_d    = csum_q ^ in_data;
               wr_en_d   = 1'b1;
               // Address wraps modulo 2^ADDR_W by construction.
               wr_addr_d = BASE_ADDR + ADDR_W'(idx_q);
               wr_data_d = {hi_q, in_data};
               idx_d     = idx_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: reset clears only the loader's own registers; the instruction
   // memory behind the write port keeps whatever image was written.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         idx_q      <= '0;
         csum_q     <= '0;
         hi_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= BASE_ADDR;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_hold_q <= 1'b1;
      end else begin
         count_q    <= count_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         hi_q       <= hi_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign done     = done_q;
   assign error    = error_q;
   assign cpu_hold = cpu_hold_q;

endmodule
